// File: rtl/upc_tag_tx.sv
// upc_tag_tx -- transmit side of the store checkout link.
//
// Accepts a 4-bit item code (bit 0 is the secret mark bit) over a
// valid/ready handshake. It sends the code on one serial line with this
// frame layout:
//   start(0), c[3], c[2], c[1], c[0], even parity, STOP_BITS x stop(1)
// Each bit lasts BIT_CYCLES clocks. The line idles high.
//
// The block also latches the expected stolen/discount verdicts of the
// accepted code. This lets a bench or display compare them against the
// checker's result.
//
// Ports:
//   clk          system clock, rising edge
//   reset        async active-high, clears all state
//   code_in      item code word, sampled on acceptance only
//   code_valid   code_in is valid
//   code_ready   high only in IDLE
//   tx_line      serial output, idle high
//   busy         high from acceptance until return to IDLE
//   done         one-cycle pulse in the final cycle of the last stop bit
//   exp_stolen   expected stolen verdict of the accepted code
//   exp_discount expected discount verdict of the accepted code
//   frame_count  frames completed, wraps 255->0
module upc_tag_tx #(
  parameter int BIT_CYCLES = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  output logic       tx_line,
  output logic       busy,
  output logic       done,
  output logic       exp_stolen,
  output logic       exp_discount,
  output logic [7:0] frame_count
);

  localparam int STOP_LEN = STOP_BITS * BIT_CYCLES;
  localparam int CW       = $clog2(STOP_LEN) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
  // Counter value one cycle before the last stop cycle. When the stop
  // phase is a single cycle this wraps to all-ones. The counter never
  // reaches all-ones in that case, because done is then raised on entry
  // to STOP instead.
  localparam logic [CW-1:0] STOP_PRE  = CW'(STOP_LEN - 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;    // cycles spent in the current bit / stop phase
  logic [1:0]    bidx;   // data bit index, 0 = MSB
  logic [3:0]    sh;     // data shift register, MSB goes out first
  logic          par;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bidx         <= '0;
      sh           <= '0;
      par          <= 1'b0;
      tx_line      <= 1'b1;
      code_ready   <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      exp_stolen   <= 1'b0;
      exp_discount <= 1'b0;
      frame_count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (code_valid) begin
            state        <= START;
            sh           <= code_in;
            par          <= ^code_in;
            exp_discount <= code_in[1] | (code_in[0] & code_in[2]);
            exp_stolen   <= (code_in[0] & ~code_in[1] & ~code_in[3]) |
                            (~code_in[0] & ~code_in[2] & ~code_in[3]);
            cnt          <= '0;
            tx_line      <= 1'b0;
            busy         <= 1'b1;
            code_ready   <= 1'b0;
          end
        end
        START: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            bidx    <= '0;
            state   <= DATA;
            tx_line <= sh[3];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (bidx == 2'd3) begin
              state   <= PARITY;
              tx_line <= par;
            end else begin
              bidx    <= bidx + 2'd1;
              sh      <= {sh[2:0], 1'b0};
              // sh[2] becomes the new MSB after this shift
              tx_line <= sh[2];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            state   <= STOP;
            tx_line <= 1'b1;
            done    <= (STOP_LEN == 1);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == STOP_LAST) begin
            cnt         <= '0;
            state       <= IDLE;
            busy        <= 1'b0;
            code_ready  <= 1'b1;
            frame_count <= frame_count + 8'd1;
          end else begin
            cnt  <= cnt + 1'b1;
            done <= (cnt == STOP_PRE);
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          tx_line    <= 1'b1;
          busy       <= 1'b0;
          code_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
